// File: rtl/novacore_cfg_loader.sv
// NovaCORE configuration master: unpacks word-streamed {uid,bus} frames and strobes
// them into the fabric configuration port with setup/hold margins around c_clk.
module novacore_cfg_loader #(
  parameter  int BUS_W     = 82,
  parameter  int UID_W     = 9,
  parameter  int IN_W      = 16,
  parameter  int N_FRAMES  = 100,
  parameter  int SETUP_CYC = 1,
  parameter  int CLK_HI    = 2,
  parameter  int CLK_LO    = 2,
  localparam int FW        = UID_W + BUS_W,
  localparam int CNT_W     = $clog2(N_FRAMES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [IN_W-1:0]  i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_mode,
  output logic [BUS_W-1:0] o_c_bus,
  output logic [UID_W-1:0] o_c_uid,
  output logic             o_c_clk,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_frame_cnt
);
  localparam int WORDS = (FW + IN_W - 1) / IN_W;
  localparam int WC_W  = $clog2(WORDS);
  localparam int T_MAX = (SETUP_CYC > CLK_HI) ? ((SETUP_CYC > CLK_LO) ? SETUP_CYC : CLK_LO)
                                              : ((CLK_HI > CLK_LO) ? CLK_HI : CLK_LO);
  localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_HIGH, S_LOW, S_DONE} state_t;

  state_t              r_state, w_next_state;
  logic [FW-IN_W-1:0]  r_frame;
  logic [FW-1:0]       w_cat;
  logic [WC_W-1:0]     r_wcnt;
  logic [TMR_W-1:0]    r_tmr;
  logic                r_in_ready, r_mode, r_c_clk, r_busy, r_done;
  logic [BUS_W-1:0]    r_c_bus;
  logic [UID_W-1:0]    r_c_uid;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic                w_xfer, w_last, w_run_start, w_low_entry, w_active;

  // Older words sit above the incoming one; pad bits fall off the top naturally.
  assign w_cat       = {r_frame, i_in_data};
  assign w_xfer      = (r_state == S_LOAD) && i_in_valid && !i_abort;
  assign w_last      = w_xfer && (r_wcnt == WC_W'(WORDS - 1));
  assign w_run_start = (w_next_state == S_LOAD) && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_low_entry = (r_state == S_HIGH) && (w_next_state == S_LOW);
  assign w_active    = (w_next_state != S_IDLE) && (w_next_state != S_DONE);

  always_comb begin
    // NOTE: default first so every path assigns w_next_state; a missing branch would infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_LOAD;
      S_LOAD:  if (w_last) w_next_state = S_SETUP;
      S_SETUP: if (r_tmr == TMR_W'(SETUP_CYC - 1)) w_next_state = S_HIGH;
      S_HIGH:  if (r_tmr == TMR_W'(CLK_HI - 1)) w_next_state = S_LOW;
      S_LOW:   if (r_tmr == TMR_W'(CLK_LO - 1))
                 w_next_state = (r_frame_cnt == CNT_W'(N_FRAMES)) ? S_DONE : S_LOAD;
      S_DONE:  if (i_start) w_next_state = S_LOAD;
      default: w_next_state = S_IDLE;
    endcase
    if (i_abort) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the frame shifter has no reset; WORDS transfers overwrite it before it is ever read.
  always_ff @(posedge clk) begin
    if (w_xfer) r_frame <= w_cat[FW-IN_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt      <= '0;
      r_tmr       <= '0;
      r_in_ready  <= 1'b0;
      r_mode      <= 1'b0;
      r_c_clk     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_c_bus     <= '0;
      r_c_uid     <= '0;
      r_frame_cnt <= '0;
    end else begin
      // Outputs are decoded from the next state so they switch together with it.
      r_in_ready <= (w_next_state == S_LOAD);
      r_c_clk    <= (w_next_state == S_HIGH);
      r_done     <= (w_next_state == S_DONE);
      r_busy     <= w_active;
      r_mode     <= w_active;
      r_tmr      <= (w_next_state != r_state) ? '0 : r_tmr + TMR_W'(1);

      if (i_abort)     r_wcnt <= '0;
      else if (w_xfer) r_wcnt <= w_last ? '0 : r_wcnt + WC_W'(1);

      if (w_last) {r_c_uid, r_c_bus} <= w_cat;

      if (w_run_start)
        r_frame_cnt <= '0;
      else if (w_low_entry && (r_frame_cnt != CNT_W'(N_FRAMES)))
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_mode      = r_mode;
  assign o_c_bus     = r_c_bus;
  assign o_c_uid     = r_c_uid;
  assign o_c_clk     = r_c_clk;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// Randomized bench for novacore_cfg_loader: frames are packed from the word-format rules
// and a scoreboard checks every c_clk rising edge against the frame that should be on the bus.
module tb_novacore_cfg_loader;
  localparam int BUS_W = 82;
  localparam int UID_W = 9;
  localparam int IN_W  = 16;
  localparam int FW    = UID_W + BUS_W;
  localparam int WORDS = 6;
  localparam int PADW  = WORDS * IN_W;
  localparam int CNT_W = 7;

  typedef struct packed {
    logic [UID_W-1:0] uid;
    logic [BUS_W-1:0] bus;
  } frame_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, start1 = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [IN_W-1:0] in_data = '0;

  logic in_ready, mode, c_clk, busy, done;
  logic [BUS_W-1:0] c_bus;
  logic [UID_W-1:0] c_uid;
  logic [CNT_W-1:0] frame_cnt;

  logic in_ready1, mode1, c_clk1, busy1, done1;
  logic [BUS_W-1:0] c_bus1;
  logic [UID_W-1:0] c_uid1;
  logic [0:0]       frame_cnt1;

  int n_checks = 0, n_fail = 0, cyc = 0, pulses = 0;
  frame_t exp_q[$];
  logic prev_cclk = 1'b0;
  bit use_fixed = 1'b0;
  logic [BUS_W-1:0] fixed_bus = '0;

  novacore_cfg_loader u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_mode(mode), .o_c_bus(c_bus), .o_c_uid(c_uid), .o_c_clk(c_clk),
    .o_busy(busy), .o_done(done), .o_frame_cnt(frame_cnt)
  );

  novacore_cfg_loader #(.N_FRAMES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_abort(abort),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready1),
    .o_mode(mode1), .o_c_bus(c_bus1), .o_c_uid(c_uid1), .o_c_clk(c_clk1),
    .o_busy(busy1), .o_done(done1), .o_frame_cnt(frame_cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] rand_bus();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[BUS_W-1:0];
  endfunction

  // Every rising c_clk must present the next frame the host fully delivered.
  always @(negedge clk) begin
    if (rst_n) begin
      if (c_clk && !prev_cclk) begin
        pulses <= pulses + 1;
        if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
        else begin
          frame_t e;
          e = exp_q.pop_front();
          check("pulse_uid", c_uid, e.uid);
          check("pulse_bus", c_bus, e.bus);
        end
      end
      if (c_clk) check("ready_in_high", in_ready, 0);
    end
    prev_cclk <= c_clk;
  end

  // Streams nwords words of consecutive-uid frames; valid is random when rnd is set.
  task automatic run_words(input int first_uid, input int nwords, input bit rnd, input bit sel);
    logic [PADW-1:0] fr;
    frame_t f;
    int w = 0, guard = 0, cur = -1, k;
    bit v;
    fr = '0;
    f  = '0;
    while (w < nwords && guard < 20000) begin
      if (w / WORDS != cur) begin
        cur   = w / WORDS;
        f.uid = UID_W'(first_uid + cur);
        f.bus = use_fixed ? fixed_bus : rand_bus();
        fr    = {5'($urandom()), f.uid, f.bus};
      end
      k = w % WORDS;
      @(negedge clk);
      guard++;
      v        = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = v;
      in_data  = fr[(WORDS-1-k)*IN_W +: IN_W];
      if (v && (sel ? in_ready1 : in_ready)) begin
        if (k == WORDS - 1 && !sel) exp_q.push_back(f);
        w++;
      end
    end
    check("drive_timeout", guard < 20000, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("drain", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int p0, t0, g;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_cclk", c_clk, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_uid", c_uid, 0);
    check("rst_bus", c_bus, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", in_ready, 0);
    check("idle_busy", busy, 0);

    // Single frame with N_FRAMES=1
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    use_fixed = 1'b1;
    fixed_bus = 82'h1_2345_6789_ABCD_EF01_2345;
    run_words(5, WORDS, 1'b0, 1'b1);
    use_fixed = 1'b0;
    check("t2_setup_cclk", c_clk1, 0);
    check("t2_uid", c_uid1, 9'h005);
    check("t2_bus", c_bus1, 82'h1_2345_6789_ABCD_EF01_2345);
    check("t2_setup_ready", in_ready1, 0);
    check("t2_setup_mode", mode1, 1);
    check("t2_main_idle", busy, 0);
    @(negedge clk);
    check("t2_high1", c_clk1, 1);
    @(negedge clk);
    check("t2_high2", c_clk1, 1);
    @(negedge clk);
    check("t2_low1", c_clk1, 0);
    check("t2_cnt", frame_cnt1, 1);
    check("t2_low_done", done1, 0);
    @(negedge clk);
    check("t2_low2", c_clk1, 0);
    @(negedge clk);
    check("t2_done", done1, 1);
    check("t2_mode", mode1, 0);
    check("t2_busy", busy1, 0);
    check("t2_uid_hold", c_uid1, 9'h005);

    // Asynchronous reset while c_clk is high
    pulse_start();
    run_words(7, WORDS, 1'b0, 1'b0);
    g = 0;
    while (!c_clk && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("t1_reached_high", c_clk, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_cclk", c_clk, 0);
    check("t1_mode", mode, 0);
    check("t1_ready", in_ready, 0);
    check("t1_busy", busy, 0);
    check("t1_uid", c_uid, 0);
    check("t1_bus", c_bus, 0);
    check("t1_cnt", frame_cnt, 0);
    check("t1_done1", done1, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full run of 100 frames, valid always high
    p0 = pulses;
    pulse_start();
    t0 = cyc;
    run_words(0, 100 * WORDS, 1'b0, 1'b0);
    g = 0;
    while (!done && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("t3_run_cycles", cyc - t0, 1100);
    check("t3_pulses", pulses - p0, 100);
    check("t3_queue", exp_q.size(), 0);
    check("t3_cnt", frame_cnt, 100);
    check("t3_mode", mode, 0);
    check("t3_busy", busy, 0);
    check("t3_uid_hold", c_uid, 99);
    check("t3_ready", in_ready, 0);
    repeat (5) @(negedge clk);
    check("t3_done_hold", done, 1);

    // New run from DONE, then backpressure with random valid
    pulse_start();
    check("t4_done_clr", done, 0);
    check("t4_mode", mode, 1);
    check("t4_cnt_clr", frame_cnt, 0);
    check("t4_ready", in_ready, 1);
    p0 = pulses;
    run_words(200, 10 * WORDS, 1'b1, 1'b0);
    drain();
    check("t4_cnt", frame_cnt, 10);
    check("t4_pulses", pulses - p0, 10);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_abort_busy", busy, 0);

    // Abort after 3 words of frame 7
    pulse_start();
    p0 = pulses;
    run_words(300, 7 * WORDS + 3, 1'b0, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_mode", mode, 0);
    check("t5_ready", in_ready, 0);
    check("t5_cclk", c_clk, 0);
    check("t5_done", done, 0);
    check("t5_cnt", frame_cnt, 7);
    check("t5_pulses", pulses - p0, 7);
    in_valid = 1'b1;
    repeat (20) @(negedge clk);
    in_valid = 1'b0;
    check("t5_no_pulse", pulses - p0, 7);
    check("t5_cnt_hold", frame_cnt, 7);
    pulse_start();
    check("t5_restart_cnt", frame_cnt, 0);
    run_words(400, 2 * WORDS, 1'b1, 1'b0);
    drain();
    check("t5_reload_cnt", frame_cnt, 2);

    // start during HIGH is ignored; start together with abort goes idle
    run_words(450, WORDS, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_high", c_clk, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_still_high", c_clk, 1);
    check("t6_busy", busy, 1);
    check("t6_cnt", frame_cnt, 2);
    @(negedge clk);
    check("t6_low", c_clk, 0);
    check("t6_cnt_inc", frame_cnt, 3);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("t6_sa_busy", busy, 0);
    check("t6_sa_mode", mode, 0);
    check("t6_sa_ready", in_ready, 0);
    check("t6_sa_cnt", frame_cnt, 3);
    check("t6_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
